uart_rx_fifo_writer: RTL and testbench

//  UART receiver in the wclk domain that feeds the async FIFO write port.
//  - Deserialises an 8N1 serial stream, LSB first, and pushes each good byte as a one-cycle wr_en/wr_data.
//  - Honours FIFO full by parking the byte in a one-entry hold register.
//  - Reports framing errors and overruns to the host.

---
 rtl/uart_rx_fifo_writer_pkg.sv | 20 ++
 rtl/uart_rx_fifo_writer_if.sv | 13 +
 rtl/uart_rx_fifo_writer_sync_2ff.sv | 23 ++
 rtl/uart_rx_fifo_writer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_fifo_writer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_fifo_writer_pkg.sv
// Shared types and defaults for the UART receiver that feeds the async FIFO write port.
package uart_rx_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam int unsigned CLKS_PER_BIT_DEF = 16;
    localparam int unsigned WIDTH_DEF        = 8;
    localparam int unsigned HALF_BIT         = CLKS_PER_BIT_DEF / 2;
    localparam int unsigned CNT_W            = $clog2(CLKS_PER_BIT_DEF);

    function automatic int unsigned half_bit(input int unsigned cpb);
        return cpb / 2;
    endfunction

    // Never narrower than one bit, so a degenerate WIDTH still elaborates.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_writer_if.sv
// FIFO write-port bundle between the UART receiver (master) and the async FIFO (slave).
interface uart_rx_fifo_writer_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic             full;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;

    modport master (input full, output wr_en, output wr_data);
    modport slave  (output full, input wr_en, input wr_data);

endinterface

// File: rtl/uart_rx_fifo_writer_sync_2ff.sv
// Generic two-flop synchroniser with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver in the wclk domain; pushes good bytes into the FIFO write port,
// parking one byte in a hold register while the FIFO is full.
module uart_rx_fifo_writer
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int unsigned WIDTH        = WIDTH_DEF
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  rxd,
    uart_rx_fifo_writer_if.master fifo,
    output logic                  busy,
    output logic                  hold_valid,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int unsigned BAUD_W = cnt_width(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = cnt_width(WIDTH);

    localparam logic [BAUD_W-1:0] HALF_M1  = BAUD_W'(half_bit(CLKS_PER_BIT) - 1);
    localparam logic [BAUD_W-1:0] LAST     = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WIDTH - 1);

    logic rx_s;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               done_q, done_d;
    logic               fe_q, fe_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hv_q, hv_d;
    logic               ovr_q, ovr_d;
    logic               drain;
    logic               wr_en;
    logic [WIDTH-1:0]   wr_data;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (wclk),
        .rst (rst),
        .d   (rxd),
        .q   (rx_s)
    );

    always_ff @(posedge wclk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            hold_q  <= '0;
            hv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            hold_q  <= hold_d;
            hv_q    <= hv_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        fe_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_q == HALF_M1) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (baud_q == LAST) begin
                    baud_d         = '0;
                    shreg_d[bit_q] = rx_s;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_q == LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                    done_d  = rx_s;
                    fe_d    = !rx_s;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pending hold byte always wins the write port; a byte completing in the same
    // cycle as a drain refills the slot, so only "held and still full" drops data.
    always_comb begin
        drain   = hv_q && !fifo.full;
        wr_en   = drain || (done_q && !hv_q && !fifo.full);
        wr_data = '0;
        if (drain) begin
            wr_data = hold_q;
        end else if (wr_en) begin
            wr_data = shreg_q;
        end

        hold_d = hold_q;
        hv_d   = hv_q;
        ovr_d  = ovr_q;
        if (done_q) begin
            if (hv_q && fifo.full) begin
                ovr_d = 1'b1;
            end else if (hv_q || fifo.full) begin
                hold_d = shreg_q;
                hv_d   = 1'b1;
            end
        end else if (drain) begin
            hv_d = 1'b0;
        end
    end

    assign fifo.wr_en   = wr_en;
    assign fifo.wr_data = wr_data;
    assign busy         = (state_q != IDLE);
    assign hold_valid   = hv_q;
    assign frame_err    = fe_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer at CLKS_PER_BIT=16, WIDTH=8.
module tb_uart_rx_fifo_writer;

    logic wclk = 1'b0;
    logic rst  = 1'b1;
    logic rxd  = 1'b1;
    logic busy, hold_valid, frame_err, overrun;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int frame_start = 0;
    int wr_count = 0;
    int fe_count = 0;
    int last_cyc = 0;
    int full_viol = 0;
    logic [7:0] last_data = '0;

    uart_rx_fifo_writer_if #(.WIDTH(8)) fifo_if ();

    uart_rx_fifo_writer #(.CLKS_PER_BIT(16), .WIDTH(8)) dut (
        .wclk       (wclk),
        .rst        (rst),
        .rxd        (rxd),
        .fifo       (fifo_if.master),
        .busy       (busy),
        .hold_valid (hold_valid),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 wclk = ~wclk;

    always @(posedge wclk) cyc++;

    always @(negedge wclk) begin
        if (fifo_if.wr_en === 1'b1) begin
            wr_count++;
            last_data = fifo_if.wr_data;
            last_cyc  = cyc;
            if (fifo_if.full !== 1'b0) full_viol++;
        end
        if (frame_err === 1'b1) fe_count++;
    end

    // Start bit falls just after the edge that sets frame_start; stop sample lands at +155.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        @(posedge wclk); #1;
        frame_start = cyc;
        rxd = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(posedge wclk);
            #1 rxd = b[i];
        end
        repeat (16) @(posedge wclk);
        #1 rxd = stop_bit;
        repeat (16) @(posedge wclk);
        #1 rxd = 1'b1;
    endtask

    task automatic clear_counts();
        wr_count = 0;
        fe_count = 0;
    endtask

    task automatic test_reset();
        fifo_if.full = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        checks++; if (fifo_if.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", fifo_if.wr_en); end
        checks++; if (fifo_if.wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got %h want 00", fifo_if.wr_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (hold_valid !== 1'b0) begin failures++; $display("FAIL reset_hold_valid got %b want 0", hold_valid); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got %b want 0", overrun); end
        @(posedge wclk); #1 rst = 1'b0;
        repeat (4) @(posedge wclk);
    endtask

    task automatic test_single_byte();
        clear_counts();
        send_frame(8'hA5, 1'b1);
        repeat (4) @(posedge wclk);
        checks++; if (wr_count !== 1) begin failures++; $display("FAIL single_count got %0d want 1", wr_count); end
        checks++; if (last_data !== 8'hA5) begin failures++; $display("FAIL single_data got %h want a5", last_data); end
        checks++; if (last_cyc !== frame_start + 155) begin failures++; $display("FAIL single_timing got %0d want %0d", last_cyc, frame_start + 155); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got %b want 0", busy); end
    endtask

    task automatic test_hold_drain();
        clear_counts();
        fifo_if.full = 1'b1;
        send_frame(8'h3C, 1'b1);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        checks++; if (wr_count !== 0) begin failures++; $display("FAIL hold_no_write got %0d want 0", wr_count); end
        checks++; if (hold_valid !== 1'b1) begin failures++; $display("FAIL hold_valid_set got %b want 1", hold_valid); end
        @(posedge wclk); #1 fifo_if.full = 1'b0;
        @(negedge wclk);
        checks++; if (fifo_if.wr_en !== 1'b1) begin failures++; $display("FAIL drain_wr_en got %b want 1", fifo_if.wr_en); end
        checks++; if (fifo_if.wr_data !== 8'h3C) begin failures++; $display("FAIL drain_wr_data got %h want 3c", fifo_if.wr_data); end
        @(negedge wclk);
        checks++; if (hold_valid !== 1'b0) begin failures++; $display("FAIL drain_hold_clear got %b want 0", hold_valid); end
        checks++; if (fifo_if.wr_en !== 1'b0) begin failures++; $display("FAIL drain_single_pulse got %b want 0", fifo_if.wr_en); end
        repeat (3) @(posedge wclk);
        checks++; if (wr_count !== 1) begin failures++; $display("FAIL drain_count got %0d want 1", wr_count); end
    endtask

    task automatic test_overrun();
        clear_counts();
        fifo_if.full = 1'b1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        checks++; if (hold_valid !== 1'b1) begin failures++; $display("FAIL ovr_hold_valid got %b want 1", hold_valid); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got %b want 1", overrun); end
        checks++; if (wr_count !== 0) begin failures++; $display("FAIL ovr_no_write got %0d want 0", wr_count); end
        @(posedge wclk); #1 fifo_if.full = 1'b0;
        repeat (5) @(posedge wclk);
        @(negedge wclk);
        checks++; if (wr_count !== 1) begin failures++; $display("FAIL ovr_release_count got %0d want 1", wr_count); end
        checks++; if (last_data !== 8'h11) begin failures++; $display("FAIL ovr_release_data got %h want 11", last_data); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        checks++; if (hold_valid !== 1'b0) begin failures++; $display("FAIL ovr_hold_clear got %b want 0", hold_valid); end
    endtask

    task automatic test_frame_error();
        clear_counts();
        send_frame(8'h55, 1'b0);
        repeat (24) @(posedge wclk);
        @(negedge wclk);
        checks++; if (fe_count !== 1) begin failures++; $display("FAIL ferr_pulses got %0d want 1", fe_count); end
        checks++; if (wr_count !== 0) begin failures++; $display("FAIL ferr_no_write got %0d want 0", wr_count); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy_after got %b want 0", busy); end
    endtask

    task automatic test_false_start();
        clear_counts();
        @(posedge wclk); #1 rxd = 1'b0;
        repeat (4) @(posedge wclk);
        #1 rxd = 1'b1;
        @(negedge wclk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_during got %b want 1", busy); end
        repeat (20) @(posedge wclk);
        @(negedge wclk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after got %b want 0", busy); end
        checks++; if (wr_count !== 0) begin failures++; $display("FAIL glitch_no_write got %0d want 0", wr_count); end
        checks++; if (fe_count !== 0) begin failures++; $display("FAIL glitch_no_ferr got %0d want 0", fe_count); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h96;
        clear_counts();
        @(posedge wclk); #1 rxd = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (16) @(posedge wclk);
            #1 rxd = b[i];
        end
        repeat (8) @(posedge wclk);
        #1;
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge wclk);
        @(negedge wclk);
        checks++; if (fifo_if.wr_en !== 1'b0) begin failures++; $display("FAIL midrst_wr_en got %b want 0", fifo_if.wr_en); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (hold_valid !== 1'b0) begin failures++; $display("FAIL midrst_hold got %b want 0", hold_valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL midrst_overrun got %b want 0", overrun); end
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL midrst_frame_err got %b want 0", frame_err); end
        @(posedge wclk); #1 rst = 1'b0;
        repeat (20) @(posedge wclk);
        clear_counts();
        send_frame(8'hF0, 1'b1);
        repeat (4) @(posedge wclk);
        checks++; if (wr_count !== 1) begin failures++; $display("FAIL midrst_next_count got %0d want 1", wr_count); end
        checks++; if (last_data !== 8'hF0) begin failures++; $display("FAIL midrst_next_data got %h want f0", last_data); end
        checks++; if (last_cyc !== frame_start + 155) begin failures++; $display("FAIL midrst_next_timing got %0d want %0d", last_cyc, frame_start + 155); end
    endtask

    task automatic test_write_rules();
        checks++; if (full_viol !== 0) begin failures++; $display("FAIL write_while_full got %0d want 0", full_viol); end
    endtask

    initial begin
        fifo_if.full = 1'b0;
        test_reset();
        test_single_byte();
        test_hold_drain();
        test_overrun();
        test_frame_error();
        test_false_start();
        test_reset_mid_frame();
        test_write_rules();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
